// File: rtl/morse_pkg.sv
// morse_pkg: symbol codes and classifier state encodings shared by the Morse receive path
package morse_pkg;

    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b11;
    localparam logic [1:0] SYM_LGAP = 2'b00;
    localparam logic [1:0] SYM_WGAP = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        LGAP  = 2'd3
    } cls_state_e;

endpackage

// File: rtl/morse_debounce.sv
// morse_debounce: 2-flop key synchronizer with an optional level filter (MORSE_DEBOUNCE_EN)
module morse_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_f
);

    logic [1:0] sync;

    // bring the asynchronous key into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], key};
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // adopt a new level only once it has been stable for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            key_f <= 1'b0;
        end else if (sync[1] == key_f) begin
            cnt   <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            key_f <= sync[1];
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end
`else
    assign key_f = sync[1];
`endif

endmodule

// File: rtl/morse_key_classifier.sv
// morse_key_classifier: turns key-down/key-up run lengths into dot/dash/letter/word symbol strobes (debounce via MORSE_DEBOUNCE_EN)
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int DOT_MAX         = 3,
    parameter int LETTER_GAP      = 4,
    parameter int WORD_GAP        = 10,
    parameter int CNT_W           = 12,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key,
    output logic [1:0]       sym,
    output logic             sym_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] counter
);

    cls_state_e       st, st_n;
    logic [CNT_W-1:0] cnt_n, inc;
    logic [1:0]       sym_n;
    logic             vld_n, k;

    morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .key_f (k)
    );

    assign state = st;
    assign inc   = (counter == '1) ? counter : counter + CNT_W'(1);

    // state, run counter and symbol output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            counter   <= '0;
            sym       <= SYM_LGAP;
            sym_valid <= 1'b0;
        end else begin
            st        <= st_n;
            counter   <= cnt_n;
            sym       <= sym_n;
            sym_valid <= vld_n;
        end
    end

    // classify each run as it ends; a press always wins over a gap threshold
    always_comb begin
        st_n  = st;
        cnt_n = counter;
        sym_n = sym;
        vld_n = 1'b0;
        case (st)
            IDLE: begin
                st_n  = k ? PRESS : IDLE;
                cnt_n = k ? CNT_W'(1) : '0;
            end
            PRESS: begin
                if (k) begin
                    cnt_n = inc;
                end else begin
                    st_n  = GAP;
                    cnt_n = CNT_W'(1);
                    sym_n = (counter <= CNT_W'(DOT_MAX)) ? SYM_DOT : SYM_DASH;
                    vld_n = 1'b1;
                end
            end
            GAP: begin
                if (k) begin
                    st_n  = PRESS;
                    cnt_n = CNT_W'(1);
                end else begin
                    cnt_n = inc;
                    if (inc == CNT_W'(LETTER_GAP)) begin
                        st_n  = LGAP;
                        sym_n = SYM_LGAP;
                        vld_n = 1'b1;
                    end
                end
            end
            LGAP: begin
                if (k) begin
                    st_n  = PRESS;
                    cnt_n = CNT_W'(1);
                end else if (inc == CNT_W'(WORD_GAP)) begin
                    st_n  = IDLE;
                    cnt_n = '0;
                    sym_n = SYM_WGAP;
                    vld_n = 1'b1;
                end else begin
                    cnt_n = inc;
                end
            end
            default: begin
                st_n  = IDLE;
                cnt_n = '0;
            end
        endcase
    end

endmodule

// File: doc/morse_key_classifier.md
# morse_key_classifier

Upstream front end of the Morse receive path. Samples a raw single-bit telegraph key, measures key-down and key-up durations in clock cycles and turns them into the 2-bit symbol stream consumed by `morse_decoder`: 01 dot, 11 dash, 00 end-of-letter, 10 word space. Each symbol is emitted as a one-cycle `sym_valid` strobe, so the decoder advances exactly once per symbol regardless of how long the operator holds the key.

## Interface
- `DOT_MAX`, default 3: longest key-down run, in cycles, classified as a dot; longer runs are dashes.
- `LETTER_GAP`, default 4: key-up run, in cycles, that ends a letter.
- `WORD_GAP`, default 10: key-up run, in cycles, that ends a word. Must be greater than `LETTER_GAP`.
- `CNT_W`, default 12: duration counter width. All thresholds must be below 2^CNT_W − 1.
- `DEBOUNCE_CYCLES`, default 4: filter length. Used only with `MORSE_DEBOUNCE_EN`.

Ports:
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `key` input, 1 bit: raw key, 1 = pressed. Asynchronous to `clk`.
- `sym` output, 2 bits: symbol code. Meaningful only while `sym_valid` = 1.
- `sym_valid` output, 1 bit: one-cycle strobe.
- `state` output, 2 bits: current FSM state (debug).
- `counter` output, `CNT_W` bits: current run length (debug).

## Operation
- `key` passes through a 2-flop synchronizer to give `key_s`. With debounce enabled, `key_s` is filtered to `key_f`. The FSM sees only `key_f` (or `key_s` when debounce is off).
- `counter` counts consecutive cycles at the current level, including the current cycle. It saturates at all-ones and never wraps.
- FSM states: IDLE = 0, PRESS = 1, GAP = 2, LGAP = 3.
- IDLE: key high → PRESS, counter = 1. Key low → stay in IDLE; no symbols are emitted and the counter holds at 0.
- PRESS: key high → counter++. Key low → emit 01 if counter ≤ `DOT_MAX`, otherwise 11; go to GAP with counter = 1.
- GAP: key high → PRESS with counter = 1; no emission (intra-letter gap). Key low → counter++; when the new value equals `LETTER_GAP`, emit 00 and go to LGAP, with counter continuing.
- LGAP: key high → PRESS with counter = 1. Key low → counter++; when the new value equals `WORD_GAP`, emit 10 and go to IDLE with counter = 0.
- Key high in the same cycle that a gap threshold would be reached: the press wins and nothing is emitted. The gap is `LETTER_GAP` − 1 cycles, which is short.
- At most one symbol is emitted per cycle. `sym` holds its last value while `sym_valid` = 0.
- A dash held past counter saturation is still a dash.
- Reset mid-press or mid-gap discards the partial symbol. No 00 or 10 is emitted on reset exit.

## Timing
- Reset values: `sym` = 2'b00, `sym_valid` = 0, `state` = IDLE, `counter` = 0. Synchronizer and debounce flops reset to 0 (key released).
- `sym`, `sym_valid`, `state` and `counter` are all registered.
- Dot/dash latency: `sym_valid` is high for the cycle after the edge at which the FSM first samples the key low. That is 3 cycles after `key` falls without debounce, plus `DEBOUNCE_CYCLES` with debounce.
- End-of-letter: 00 is strobed in the cycle after the `LETTER_GAP`-th consecutive low sample.
- Word space: 10 is strobed in the cycle after the `WORD_GAP`-th consecutive low sample.
- No backpressure: the downstream block must accept any strobe.

## Configuration
- `MORSE_DEBOUNCE_EN` defined: `key_f` changes only after `key_s` has held the new level for `DEBOUNCE_CYCLES` consecutive cycles. Shorter glitches are invisible to the FSM.
- `MORSE_DEBOUNCE_EN` undefined: the FSM uses `key_s` directly. `DEBOUNCE_CYCLES` is ignored, and a one-cycle glitch produces a dot.

## Structure
- Shared package `morse_pkg`:
  - Symbol constants SYM_DOT = 2'b01, SYM_DASH = 2'b11, SYM_LGAP = 2'b00, SYM_WGAP = 2'b10.
  - Classifier state encodings.
  - The package is also used by `morse_decoder`.
- One sub-module, `morse_debounce`: synchronizer plus filter counter. It is instantiated always; the filter logic is compiled in only with `MORSE_DEBOUNCE_EN`.

## Test plan
All scenarios use defaults, debounce off, and key lengths measured at the FSM input.
- Key high 2 cycles, then low 20 cycles → strobes 01, 00, 10 in that order; `state` ends in IDLE with `counter` = 0.
- Key high 5, low 2, high 1, low 20 → strobes 11, 01, 00, 10, with no 00 between the two presses.
- Gap exactly 3 cycles between two dots → no 00. Gap of 4 cycles → 00 strobed exactly once.
- Assert `rst` during a 6-cycle press, release, then hold the key low → no strobes; all outputs at reset values.
- Key held high 5000 cycles (`CNT_W` = 12) → `counter` saturates at 4095; a single 11 on release.
- With `MORSE_DEBOUNCE_EN` and `DEBOUNCE_CYCLES` = 4: 2-cycle glitches on `key` → no strobes. A clean 3-cycle press → 01 delayed by 4 extra cycles.
